mmio_regfile: RTL and testbench

MMIO_REGFILE -- requirements
Module: mmio_regfile

---
 rtl/mmio_regfile_if.sv | 23 ++
 rtl/mmio_regfile.sv | 130 +++++++++++++
 tb/tb_mmio_regfile.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_regfile_if.sv
// Bus bundle for mmio_regfile: CPU-side strobes, address and data, plus the
// pass-through path to the external RAM that shares the address space.
interface mmio_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 12
) ();
  logic                  wEn;
  logic                  rEn;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           dataIn;
  logic [31:0]           dataOut;
  logic [31:0]           ramDataOut;
  logic                  ramWEn;

  modport master (
    output wEn, rEn, addr, dataIn, ramDataOut,
    input  dataOut, ramWEn
  );

  modport slave (
    input  wEn, rEn, addr, dataIn, ramDataOut,
    output dataOut, ramWEn
  );
endinterface

// File: rtl/mmio_regfile.sv
// MMIO register window: debounced buttons (LEVEL/EVENT) and RW output registers.
// Define MMIO_TIMER_EN to add a free-running 32-bit TIMER after the OUT registers.
module mmio_regfile #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned MMIO_BASE       = 1000,
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned NUM_OUT         = 3,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  mmio_regfile_if.slave                bus,
  input  logic [NUM_BTN-1:0]           btn,
  output logic [NUM_OUT*OUT_WIDTH-1:0] outRegs
);

`ifdef MMIO_TIMER_EN
  localparam int unsigned TimerOn = 1;
`else
  localparam int unsigned TimerOn = 0;
`endif
  localparam int unsigned   NumRegs = 2 + NUM_OUT + TimerOn;
  localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]                sync1_q, sync2_q;
  logic [NUM_BTN-1:0]                level_q, level_d, level_dly_q;
  logic [NUM_BTN-1:0][CntW-1:0]      cnt_q, cnt_d;
  logic [NUM_BTN-1:0]                evt_q, evt_d, evt_clr;
  logic [NUM_OUT-1:0][OUT_WIDTH-1:0] out_q, out_d;

  logic [31:0] addr_ext, off;
  logic        in_win, hit_evt;

  assign addr_ext = 32'(bus.addr);
  assign off      = addr_ext - MMIO_BASE;
  assign in_win   = (addr_ext >= MMIO_BASE) && (off < NumRegs);
  assign hit_evt  = in_win && (off == 32'd1);

  assign bus.ramWEn = bus.wEn & ~in_win;
  assign outRegs    = out_q;

  // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CntLast) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Set wins over clear so a press coinciding with a clear is not lost.
  always_comb begin
    evt_clr = '0;
    if (bus.rEn && hit_evt) evt_clr = '1;
    if (bus.wEn && hit_evt) evt_clr = evt_clr | bus.dataIn[NUM_BTN-1:0];
    evt_d = (evt_q & ~evt_clr) | (level_q & ~level_dly_q);
  end

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < int'(NUM_OUT); k++) begin
      if (bus.wEn && in_win && (off == 32'(2 + k))) out_d[k] = bus.dataIn[OUT_WIDTH-1:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (bus.wEn && in_win && (off == 32'(2 + NUM_OUT))) timer_d = bus.dataIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`endif

  always_comb begin
    bus.dataOut = '0;
    if (!in_win) begin
      bus.dataOut = bus.ramDataOut;
    end else if (off == 32'd0) begin
      bus.dataOut = 32'(level_q);
    end else if (off == 32'd1) begin
      bus.dataOut = 32'(evt_q);
    end else begin
      for (int k = 0; k < int'(NUM_OUT); k++) begin
        if (off == 32'(2 + k)) bus.dataOut = 32'(out_q[k]);
      end
`ifdef MMIO_TIMER_EN
      if (off == 32'(2 + NUM_OUT)) bus.dataOut = timer_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      cnt_q       <= '0;
      evt_q       <= '0;
      out_q       <= '0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
      out_q       <= out_d;
    end
  end

  logic unused_data;
  assign unused_data = ^bus.dataIn;

endmodule

// File: tb/tb_mmio_regfile.sv
// Directed bench for mmio_regfile: debounce timing, EVENT clear rules,
// OUT registers, RAM pass-through and asynchronous reset.
module tb_mmio_regfile;
  localparam int unsigned Base = 1000;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic [23:0] outRegs;
  int         n_total;
  int         n_bad;

  mmio_regfile_if #(.ADDR_WIDTH(12)) bus ();

  mmio_regfile #(
    .ADDR_WIDTH(12), .MMIO_BASE(Base), .NUM_BTN(2), .NUM_OUT(3), .OUT_WIDTH(8),
    .DEBOUNCE_CYCLES(16)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .btn     (btn),
    .outRegs (outRegs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; registers update on the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    bus.addr = a;
    #1 d = bus.dataOut;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.addr   = a;
    bus.dataIn = d;
    bus.wEn    = 1'b1;
    tick(1);
    bus.wEn    = 1'b0;
  endtask

  logic [31:0] d;
  int          n;

  initial begin
    n_total        = 0;
    n_bad          = 0;
    reset          = 1'b1;
    btn            = 2'b00;
    bus.wEn        = 1'b1;
    bus.rEn        = 1'b0;
    bus.addr       = 12'd5;
    bus.dataIn     = 32'h0;
    bus.ramDataOut = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    check("rst_ramwen", 32'(bus.ramWEn), 32'd1);
    check("rst_outregs", 32'(outRegs), 32'd0);
    bus.wEn = 1'b0;
    #1 check("rst_ramwen_lo", 32'(bus.ramWEn), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);

    peek(12'(Base + 0), d); check("rst_level", d, 32'h0);
    peek(12'(Base + 1), d); check("rst_event", d, 32'h0);
    peek(12'(Base + 2), d); check("rst_out0", d, 32'h0);
    peek(12'(Base + 4), d); check("rst_out2", d, 32'h0);

    // btn[0] press: LEVEL rises about 2+16 edges later, EVENT one edge after that.
    btn = 2'b01;
    n   = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      peek(12'(Base + 0), d);
      if (d[0]) begin
        n = i;
        break;
      end
    end
    check("press_latency_ok", 32'((n >= 17) && (n <= 19)), 32'd1);
    check("press_level", d, 32'h1);
    peek(12'(Base + 1), d); check("press_event_not_yet", d, 32'h0);
    tick(1);
    peek(12'(Base + 1), d); check("press_event", d, 32'h1);

    // 10-cycle glitch on btn[1] must be rejected.
    btn = 2'b11;
    tick(10);
    btn = 2'b01;
    tick(25);
    peek(12'(Base + 0), d); check("glitch_level", d, 32'h1);
    peek(12'(Base + 1), d); check("glitch_event", d, 32'h1);

    btn = 2'b11;
    tick(22);
    peek(12'(Base + 0), d); check("both_level", d, 32'h3);
    peek(12'(Base + 1), d); check("both_event", d, 32'h3);

    // Read-to-clear.
    bus.addr = 12'(Base + 1);
    bus.rEn  = 1'b1;
    #1 check("rdclr_data", bus.dataOut, 32'h3);
    tick(1);
    bus.rEn = 1'b0;
    peek(12'(Base + 1), d); check("rdclr_after", d, 32'h0);

    // Release: falling edges raise no events.
    btn = 2'b00;
    tick(22);
    peek(12'(Base + 0), d); check("release_level", d, 32'h0);
    peek(12'(Base + 1), d); check("release_event", d, 32'h0);

    // Press both again, then W1C of 0x2.
    btn = 2'b11;
    tick(22);
    peek(12'(Base + 1), d); check("repress_event", d, 32'h3);
    bus.addr   = 12'(Base + 1);
    bus.dataIn = 32'h2;
    bus.wEn    = 1'b1;
    #1 check("w1c_ramwen", 32'(bus.ramWEn), 32'd0);
    tick(1);
    bus.wEn = 1'b0;
    peek(12'(Base + 1), d); check("w1c_event", d, 32'h1);

    // New press on btn[0] lands on the same edge as a read-clear.
    btn = 2'b10;
    tick(22);
    bus.addr = 12'(Base + 1);
    bus.rEn  = 1'b1;
    tick(1);
    bus.rEn = 1'b0;
    peek(12'(Base + 1), d); check("pre_race_event", d, 32'h0);
    btn = 2'b11;
    n   = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      peek(12'(Base + 0), d);
      if (d[0]) begin
        n = i;
        break;
      end
    end
    check("race_level_rose", 32'(n != 0), 32'd1);
    bus.addr = 12'(Base + 1);
    bus.rEn  = 1'b1;
    tick(1);
    bus.rEn = 1'b0;
    peek(12'(Base + 1), d); check("race_event_kept", d, 32'h1);

    // OUT registers and RAM routing.
    wr(12'(Base + 2), 32'h1A5);
    peek(12'(Base + 2), d); check("out0_read", d, 32'hA5);
    check("out0_pins", 32'(outRegs), 32'h0000A5);
    wr(12'(Base + 4), 32'h3C);
    check("out2_pins", 32'(outRegs), 32'h3C00A5);
    wr(12'(Base + 0), 32'h0);
    peek(12'(Base + 0), d); check("level_wr_ignored", d, 32'h3);
    bus.addr   = 12'd5;
    bus.dataIn = 32'h55;
    bus.wEn    = 1'b1;
    #1 check("ram_wen", 32'(bus.ramWEn), 32'd1);
    tick(1);
    bus.wEn = 1'b0;
    bus.ramDataOut = 32'h1234_5678;
    peek(12'd5, d); check("ram_read", d, 32'h1234_5678);
    peek(12'(Base - 1), d); check("ram_below_base", d, 32'h1234_5678);

`ifdef MMIO_TIMER_EN
    wr(12'(Base + 5), 32'hFFFF_FFFE);
    peek(12'(Base + 5), d); check("timer_load", d, 32'hFFFF_FFFE);
    tick(1);
    peek(12'(Base + 5), d); check("timer_max", d, 32'hFFFF_FFFF);
    tick(1);
    peek(12'(Base + 5), d); check("timer_wrap", d, 32'h0);
    tick(3);
    reset = 1'b1;
    peek(12'(Base + 5), d); check("timer_async_rst", d, 32'h0);
`else
    peek(12'(Base + 5), d); check("no_timer_ram", d, 32'h1234_5678);
    bus.wEn = 1'b1;
    #1 check("no_timer_ramwen", 32'(bus.ramWEn), 32'd1);
    bus.wEn = 1'b0;
    tick(3);
    reset = 1'b1;
`endif
    // Reset asserted mid-cycle clears state without a clock edge.
    peek(12'(Base + 2), d); check("async_rst_out0", d, 32'h0);
    check("async_rst_pins", 32'(outRegs), 32'h0);
    peek(12'(Base + 0), d); check("async_rst_level", d, 32'h0);

    // Buttons held through reset release must still debounce and raise EVENT.
    btn = 2'b11;
    tick(2);
    reset = 1'b0;
    tick(24);
    peek(12'(Base + 0), d); check("held_level", d, 32'h3);
    peek(12'(Base + 1), d); check("held_event", d, 32'h3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
